// File: rtl/exhaustive_vector_sweeper.sv
// -----------------------------------------------------------------------------
// exhaustive_vector_sweeper
//
// Purpose:
//   Drives an N-bit stimulus vector through all 2^N combinations, holding each
//   one for DWELL clock cycles. On the last cycle of each dwell, the single-bit
//   response of a combinational DUT is captured into a truth-table register,
//   and a running count of ones is updated. A start/busy/done handshake
//   controls the sweep. The sweep can be frozen with pause.
//
// Parameters:
//   N      vector width, 1..8
//   DWELL  cycles each vector is held, >= 1
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset; overrides every other input
//   start        begins or restarts a sweep (honoured in IDLE and DONE)
//   pause        freezes the sweep while in RUN
//   dut_out      DUT response to vec
//   vec          stimulus vector to the DUT
//   vec_valid    vec is being actively swept (RUN)
//   busy         sweep in progress (RUN)
//   done         sweep finished (level, held until the next start)
//   truth_table  bit k = dut_out captured while vec == k
//   ones_cnt     number of ones in truth_table
//
// Configuration:
//   GRAY_ORDER_EN  when defined, vectors are visited in reflected Gray order,
//                  so that one input toggles per step. truth_table is still
//                  indexed by the binary value of vec.
// -----------------------------------------------------------------------------
module exhaustive_vector_sweeper #(
  parameter int N     = 4,
  parameter int DWELL = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              dut_out,
  output logic [N-1:0]      vec,
  output logic              vec_valid,
  output logic              busy,
  output logic              done,
  output logic [(1<<N)-1:0] truth_table,
  output logic [N:0]        ones_cnt
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DCNT_MAX = DW'(DWELL - 1);
  localparam logic [N-1:0]  IDX_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       idx_q, idx_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [N-1:0]       vec_q, vec_d;
  logic [(1<<N)-1:0]  tt_q, tt_d;
  logic [N:0]         ones_q, ones_d;

  // Sweep order. The truth table is always indexed by the vector value itself,
  // so the final results do not depend on the order.
  function automatic logic [N-1:0] map_idx(input logic [N-1:0] i);
`ifdef GRAY_ORDER_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the truth table is a plain register, not a RAM, so it can be
      // cleared by reset along with the rest of the state.
      state_q <= S_IDLE;
      idx_q   <= '0;
      dcnt_q  <= '0;
      vec_q   <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      vec_q   <= vec_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold value first. This ensures
    // that any branch that leaves one unassigned cannot infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    vec_d   = vec_q;
    tt_d    = tt_q;
    ones_d  = ones_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          dcnt_d  = '0;
          vec_d   = map_idx('0);
          tt_d    = '0;
          ones_d  = '0;
        end
      end

      S_RUN: begin
        // While paused, nothing moves, and no capture happens, even on the
        // last cycle of a dwell.
        if (!pause) begin
          if (dcnt_q == DCNT_MAX) begin
            dcnt_d      = '0;
            tt_d[vec_q] = dut_out;
            ones_d      = ones_q + (N+1)'(dut_out);
            if (idx_q == IDX_MAX) begin
              state_d = S_DONE;
            end else begin
              idx_d = idx_q + N'(1);
              vec_d = map_idx(idx_q + N'(1));
            end
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign vec         = vec_q;
  assign truth_table = tt_q;
  assign ones_cnt    = ones_q;
  assign busy        = (state_q == S_RUN);
  assign vec_valid   = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);

endmodule
